// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, external hold
// and saturating stall/flush counters for the 5-stage MIPS datapath.
module id_ex_hazard_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               ID_Valid,
  input  logic               ID_UsesRt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PCPlus4,
  input  logic [4:0]         ID_rs,
  input  logic [4:0]         ID_rt,
  input  logic [4:0]         ID_rd,
  output logic               EX_Valid,
  output logic               EX_RegWrite,
  output logic               EX_MemtoReg,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_ALUSrc,
  output logic               EX_RegDst,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic [DATA_W-1:0]  EX_PCPlus4,
  output logic [4:0]         EX_rs,
  output logic [4:0]         EX_rt,
  output logic [4:0]         EX_rd,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  logic loadUse;
  logic insertBubble;
  logic advance;

  // A load in EX whose destination is read by the valid ID instruction; $zero never hazards.
  assign loadUse = EX_Valid & EX_MemRead & (EX_rt != 5'd0) & ID_Valid &
                   ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));

  assign insertBubble = Flush | loadUse;

  // Upstream handshake: PCWrite/IFIDWrite low means PC and IF/ID must keep their contents
  // this cycle; high means the ID instruction is consumed at the next rising edge.
  assign advance   = ~Hold & (Flush | ~loadUse);
  assign PCWrite   = ~Rst_n | advance;
  assign IFIDWrite = ~Rst_n | advance;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      EX_Valid     <= 1'b0;
      EX_RegWrite  <= 1'b0;
      EX_MemtoReg  <= 1'b0;
      EX_MemRead   <= 1'b0;
      EX_MemWrite  <= 1'b0;
      EX_ALUSrc    <= 1'b0;
      EX_RegDst    <= 1'b0;
      EX_ALUOp     <= '0;
      EX_ReadData1 <= '0;
      EX_ReadData2 <= '0;
      EX_Imm       <= '0;
      EX_PCPlus4   <= '0;
      EX_rs        <= '0;
      EX_rt        <= '0;
      EX_rd        <= '0;
    end else if (!Hold) begin
      if (insertBubble) begin
        EX_Valid     <= 1'b0;
        EX_RegWrite  <= 1'b0;
        EX_MemtoReg  <= 1'b0;
        EX_MemRead   <= 1'b0;
        EX_MemWrite  <= 1'b0;
        EX_ALUSrc    <= 1'b0;
        EX_RegDst    <= 1'b0;
        EX_ALUOp     <= '0;
        EX_ReadData1 <= '0;
        EX_ReadData2 <= '0;
        EX_Imm       <= '0;
        EX_PCPlus4   <= '0;
        EX_rs        <= '0;
        EX_rt        <= '0;
        EX_rd        <= '0;
      end else begin
        EX_Valid     <= ID_Valid;
        EX_RegWrite  <= ID_RegWrite;
        EX_MemtoReg  <= ID_MemtoReg;
        EX_MemRead   <= ID_MemRead;
        EX_MemWrite  <= ID_MemWrite;
        EX_ALUSrc    <= ID_ALUSrc;
        EX_RegDst    <= ID_RegDst;
        EX_ALUOp     <= ID_ALUOp;
        EX_ReadData1 <= ID_ReadData1;
        EX_ReadData2 <= ID_ReadData2;
        EX_Imm       <= ID_Imm;
        EX_PCPlus4   <= ID_PCPlus4;
        EX_rs        <= ID_rs;
        EX_rt        <= ID_rt;
        EX_rd        <= ID_rd;
      end
    end
  end

  // Flush outranks a load-use hazard, so only one of the counters moves per edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (!Hold) begin
      if (Flush) begin
        if (FlushCount != '1) FlushCount <= FlushCount + 1'b1;
      end else if (loadUse) begin
        if (StallCount != '1) StallCount <= StallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized and directed bench for id_ex_hazard_stage; a reference model pushes the
// expected EX state per cycle and an independent monitor pops and compares.
module tb_id_ex_hazard_stage;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memtoReg;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    logic        regDst;
    logic [3:0]  aluOp;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    ex_t              ex;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             pcw;
    logic             ifw;
  } exp_t;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic Hold = 1'b0;
  logic Flush = 1'b0;
  logic ID_UsesRt = 1'b0;
  ex_t  idIn = '0;
  always #5 Clk = ~Clk;

  logic               EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
  logic               EX_ALUSrc, EX_RegDst;
  logic [ALUOP_W-1:0] EX_ALUOp;
  logic [DATA_W-1:0]  EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4;
  logic [4:0]         EX_rs, EX_rt, EX_rd;
  logic               PCWrite, IFIDWrite;
  logic [CNT_W-1:0]   StallCount, FlushCount;

  id_ex_hazard_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Hold(Hold), .Flush(Flush),
    .ID_Valid(idIn.valid), .ID_UsesRt(ID_UsesRt),
    .ID_RegWrite(idIn.regWrite), .ID_MemtoReg(idIn.memtoReg), .ID_MemRead(idIn.memRead),
    .ID_MemWrite(idIn.memWrite), .ID_ALUSrc(idIn.aluSrc), .ID_RegDst(idIn.regDst),
    .ID_ALUOp(idIn.aluOp), .ID_ReadData1(idIn.rd1), .ID_ReadData2(idIn.rd2),
    .ID_Imm(idIn.imm), .ID_PCPlus4(idIn.pc4),
    .ID_rs(idIn.rs), .ID_rt(idIn.rt), .ID_rd(idIn.rd),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc),
    .EX_RegDst(EX_RegDst), .EX_ALUOp(EX_ALUOp),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // scoreboard
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // reference model: the instruction sitting in EX and the event tallies
  ex_t m_ex = '0;
  int  m_stall = 0;
  int  m_flush = 0;

  function automatic ex_t rand_ex();
    ex_t t;
    t.valid    = ($urandom_range(0, 7) != 0);
    t.regWrite = 1'($urandom_range(0, 1));
    t.memtoReg = 1'($urandom_range(0, 1));
    t.memRead  = 1'($urandom_range(0, 1));
    t.memWrite = 1'($urandom_range(0, 1));
    t.aluSrc   = 1'($urandom_range(0, 1));
    t.regDst   = 1'($urandom_range(0, 1));
    t.aluOp    = 4'($urandom_range(0, 15));
    t.rd1      = $urandom;
    t.rd2      = $urandom;
    t.imm      = $urandom;
    t.pc4      = $urandom;
    t.rs       = 5'($urandom_range(0, 3));
    t.rt       = 5'($urandom_range(0, 3));
    t.rd       = 5'($urandom_range(0, 31));
    return t;
  endfunction

  function automatic ex_t mk(input logic valid, input logic regWrite, input logic memRead,
                             input int rs, input int rt, input int rd);
    ex_t t;
    t          = rand_ex();
    t.valid    = valid;
    t.regWrite = regWrite;
    t.memRead  = memRead;
    t.rs       = 5'(rs);
    t.rt       = 5'(rt);
    t.rd       = 5'(rd);
    return t;
  endfunction

  // driver: applies one cycle of inputs and records what the stage must do with them
  task automatic drive(input ex_t id, input logic usesRt, input logic hold,
                       input logic flush, input logic rstn);
    exp_t e;
    bit   hazard;
    @(negedge Clk);
    idIn      = id;
    ID_UsesRt = usesRt;
    Hold      = hold;
    Flush     = flush;
    Rst_n     = rstn;
    if (!rstn) begin
      m_ex = '0; m_stall = 0; m_flush = 0;
      e.pcw = 1'b1; e.ifw = 1'b1;
    end else begin
      hazard = m_ex.valid && m_ex.memRead && m_ex.rt != 0 && id.valid &&
               (m_ex.rt == id.rs || (usesRt && m_ex.rt == id.rt));
      if (hold) begin
        e.pcw = 1'b0; e.ifw = 1'b0;
      end else if (flush) begin
        e.pcw = 1'b1; e.ifw = 1'b1;
        m_ex = '0;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (hazard) begin
        e.pcw = 1'b0; e.ifw = 1'b0;
        m_ex = '0;
        if (m_stall < CNT_MAX) m_stall++;
      end else begin
        e.pcw = 1'b1; e.ifw = 1'b1;
        m_ex = id;
      end
    end
    e.ex    = m_ex;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // monitor: handshake outputs sampled before the edge, registers after it
  initial begin : monitor
    logic pcw_s, ifw_s;
    ex_t  act;
    exp_t e;
    forever begin
      @(negedge Clk);
      #3;
      pcw_s = PCWrite;
      ifw_s = IFIDWrite;
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc,
               EX_RegDst, EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4,
               EX_rs, EX_rt, EX_rd};
        check("pc_write", 160'(pcw_s), 160'(e.pcw));
        check("ifid_write", 160'(ifw_s), 160'(e.ifw));
        check("ex_regs", 160'(act), 160'(e.ex));
        check("stall_count", 160'(StallCount), 160'(e.stall));
        check("flush_count", 160'(FlushCount), 160'(e.flush));
      end
    end
  end

  // stimulus
  initial begin : stimulus
    ex_t lw5, dep5;
    // reset with random ID activity
    repeat (3) drive(rand_ex(), 1'b1, 1'b0, 1'b0, 1'b0);
    // add r3,r1,r2
    drive(mk(1, 1, 0, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1);
    // lw r5 then a dependent instruction: one bubble, then it advances
    lw5  = mk(1, 1, 1, 0, 5, 0);
    dep5 = mk(1, 1, 0, 5, 6, 7);
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    // lw r0 then use of r0: no hazard
    drive(mk(1, 1, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 0, 0, 0, 4), 1'b1, 1'b0, 1'b0, 1'b1);
    // lw r5 then rt=5 not used as source: no hazard
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 0, 1, 5, 8), 1'b0, 1'b0, 1'b0, 1'b1);
    // back-to-back dependent loads
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 1, 5, 5, 0), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 1, 5, 5, 0), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 0, 2, 5, 9), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 0, 2, 5, 9), 1'b1, 1'b0, 1'b0, 1'b1);
    // flush wins over a load-use hazard
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b1, 1'b1);
    // hold three cycles mid-stream with a pending hazard
    drive(mk(1, 1, 0, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(dep5, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    // reset asserted while a stall is pending
    drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      drive(rand_ex(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
    end
    // saturation of both counters
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      drive(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(dep5, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < CNT_MAX + 6; i++) drive(rand_ex(), 1'b1, 1'b0, 1'b1, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1);

    // final report
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, combined with load-use hazard detection.
- Registers decoded control, operands, immediate and register specifiers from ID, and presents EX_rs/EX_rt/EX_RegWrite etc. to the EX-stage forwarding unit and ALU muxes.
- Detects load-use hazards that forwarding cannot resolve, freezes PC and IF/ID, and injects a one-cycle bubble.
- Supports a branch flush, an external hold, and a saturating stall counter for performance checks.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields.
- ALUOP_W, 4, width of the ALUOp control field.
- CNT_W, 16, width of the StallCount / FlushCount counters.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Hold  in  1  external freeze (memory wait); holds all state.
- Flush  in  1  squash the instruction currently in ID (taken branch/jump).
- ID_Valid  in  1  ID holds a real instruction.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst  in  1 each  decoded control.
- ID_ALUOp  in  ALUOP_W  ALU operation.
- ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4  in  DATA_W each  operands, sign-extended immediate, PC+4.
- ID_rs, ID_rt, ID_rd  in  5 each  register specifiers.
- EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst  out  1 each  registered control.
- EX_ALUOp  out  ALUOP_W  registered ALUOp.
- EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4  out  DATA_W each  registered data.
- EX_rs, EX_rt, EX_rd  out  5 each  registered specifiers (to forwarding unit).
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- StallCount  out  CNT_W  saturating count of load-use bubbles.
- FlushCount  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (Rst_n=0, asynchronous): all EX_* outputs 0, EX_Valid=0, both counters 0. PCWrite and IFIDWrite are combinational and evaluate to 1 while in reset.
- Load-use hazard (combinational): LU = EX_Valid & EX_MemRead & (EX_rt != 0) & ID_Valid & ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt))).
- Per rising edge, priority order: Hold > Flush > LU > normal.
- Hold: every register keeps its value. PCWrite=0, IFIDWrite=0. Counters do not change.
- Flush: load a bubble (all control outputs 0, EX_Valid=0; data and specifier fields are don't-care but are driven to 0). PCWrite=1, IFIDWrite=1. FlushCount increments. LU is ignored and StallCount does not change.
- LU with no Flush: load a bubble. PCWrite=0, IFIDWrite=0. StallCount increments.
- Normal: load all ID_* fields into EX_*, with EX_Valid=ID_Valid. PCWrite=1, IFIDWrite=1.
- Latency: one cycle from ID_* to EX_*.
- A load-use stall lasts exactly one cycle: the bubble clears EX_MemRead, so LU drops on the next cycle and the held ID instruction then advances. The loaded value then reaches EX by MEM/WB forwarding.
- Back-to-back loads with a dependency each cause one bubble.
- Counters saturate at all-ones and never wrap.
- A bubble (EX_Valid=0) never raises LU, even if a stale EX_MemRead value would otherwise match.
- No hazard is raised on $zero (EX_rt == 0).
- Rst_n asserted mid-stall: outputs clear immediately. The stall releases because EX_Valid=0.

Test Plan:
- Reset: hold Rst_n=0 with random ID inputs -> all EX_*=0, counters 0, PCWrite=1, IFIDWrite=1. Release reset, apply add r3,r1,r2 -> next cycle EX_rs=1, EX_rt=2, EX_rd=3, EX_RegWrite=1, EX_Valid=1.
- Load-use: lw r5 in EX (EX_MemRead=1, EX_rt=5), ID instruction with rs=5 -> PCWrite=0, IFIDWrite=0. Next cycle EX_Valid=0, StallCount=1. Following cycle the dependent instruction is in EX with EX_rs=5.
- No-hazard cases: lw r0 followed by use of r0, and lw r5 followed by an instruction with ID_rt=5 and ID_UsesRt=0 -> no stall, StallCount unchanged.
- Flush during LU: hazard condition present with Flush=1 -> PCWrite=1, bubble loaded, FlushCount=1, StallCount=0.
- Hold: assert Hold for 3 cycles mid-stream -> EX_* unchanged, PCWrite=0, both counters unchanged. Release -> normal flow resumes.
- Saturation: force 65536 load-use stalls -> StallCount reaches 0xFFFF and stays at 0xFFFF.
